alu_bist_ctrl: RTL
==================

# alu_bist_ctrl

Built-in self-test controller that sits on the host side of the 4-bit ALU and drives its operand and opcode inputs. It sweeps every opcode/operand combination (2048 vectors) and samples the ALU's packed output. Each sample is checked against an internal golden model. It reports pass/fail, a saturating mismatch count and the first failing vector, which makes silicon bring-up of the ALU possible without an external pattern generator.

## Interface
Parameters:
- SETTLE, default 1: cycles each vector is held on the ALU inputs before the output is sampled; legal 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a sweep; sampled only in IDLE or DONE
- alu_a  out  4  operand A to ALU
- alu_b  out  4  operand B to ALU
- alu_op  out  3  opcode to ALU
- alu_y  in  8  ALU output {zero, carry, res[5:0]}
- busy  out  1  sweep in progress
- done  out  1  sweep complete; level, held until next accepted start or rst
- pass  out  1  1 when done and err_cnt==0; 0 otherwise
- err_cnt  out  8  mismatch count, saturates at 255
- fail_vec  out  19  first mismatch {op[2:0], b[3:0], a[3:0], got[7:0]}; 0 if none

## Operation
- Vector index v[10:0] = {op, b, a}. a increments fastest. The sweep runs from v=0 to v=2047 and drives alu_op/alu_b/alu_a directly from v.
- Golden model: R is an 8-bit result computed with A and B zero-extended.
  - op0: R = A+B
  - op1: R = (A−B) mod 256
  - op2: R = A*B
  - op3: R = A/B if B≠0, else R=0
  - op4: R = A&B
  - op5: R = A|B
  - op6: R = ~{4'h0,A}, so R[7:4]=4'hF
  - op7: R = A^B
- Expected word = {Z, 1'b0, R[5:0]}.
  - Z = (R==0) for every opcode.
  - For op3 with B=0, Z=1.
  - Bit 6 (carry) is 0 for every opcode.
- The comparison is on all 8 bits. On mismatch, err_cnt increments, saturating at 255. If this is the first mismatch of the sweep, fail_vec = {v, alu_y_captured}.
- FSM states:
  - IDLE → DRIVE on start. On entry, v, err_cnt and fail_vec are cleared and busy is set.
  - DRIVE: hold the vector for SETTLE cycles. On the last cycle, capture alu_y into an internal register, then go to CHECK.
  - CHECK: compare and update counters. If v==2047, go to DONE; else v++ and go to DRIVE.
  - DONE: busy=0, done=1, pass = (err_cnt==0). Go to DRIVE on start, with the same clears as in IDLE.
- Boundary conditions:
  - start while busy is ignored.
  - rst at any cycle returns to IDLE with all outputs at reset value on the next edge. A partial sweep is discarded.
  - v does not wrap. The terminal vector is detected by equality with 2047.

## Timing
- Reset values: alu_a=0, alu_b=0, alu_op=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0; state IDLE.
- start high at edge k: busy=1 and the alu_* outputs carry vector 0 from k+1.
- Each vector occupies SETTLE+1 cycles. alu_y is sampled at the edge ending the last DRIVE cycle, so the ALU has SETTLE full cycles to settle.
- The alu_* outputs change only at the edge leaving CHECK, and hold stable through DRIVE and CHECK.
- done=1, busy=0 and pass valid from edge k + 1 + 2048·(SETTLE+1). With SETTLE=1 this is k+4097.
- After DONE, the alu_* outputs hold vector 2047 until the next start or rst.

## Test plan
- Correct behavioural ALU attached, SETTLE=1, start at cycle 10:
  - busy rises at cycle 11 and done at cycle 4107.
  - pass=1, err_cnt=0, fail_vec=0.
- ALU output bit0 stuck at 0:
  - First mismatch is op0 a=1 b=0 (expected 0x01).
  - fail_vec = {3'd0, 4'd0, 4'd1, 8'h00}, err_cnt=255 (saturated), pass=0.
- ALU returns zero=0 for op3 with B=0:
  - fail_vec = {3'd3, 4'd0, 4'd0, 8'h00}.
  - err_cnt=16 (one per A value), pass=0.
- NOT check with a correct ALU, observed at v=0x600 (op6, a=0, b=0):
  - alu_y = 8'h3F matches the expected word.
  - The same check at op6 a=15 gives expected 8'h30, not zero.
- Control boundary conditions:
  - start pulses during busy leave v progression unchanged.
  - rst asserted at cycle 2000 gives all outputs 0 at cycle 2001.
  - A new start after rst runs a full sweep with done at +4097 cycles.
- SETTLE=3 with a 2-cycle-delayed ALU model:
  - pass=1 and done at k+8193.
  - Repeat with SETTLE=1: err_cnt>0.

Source files
------------

// File: rtl/alu_bist_ctrl_if.sv
// Host/ALU bus of the ALU self-test controller: start/status toward the host, operands and result toward the ALU.
// master = controller side; slave = host plus the ALU under test.
interface alu_bist_ctrl_if;
  logic        start;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [2:0]  alu_op;
  logic [7:0]  alu_y;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  err_cnt;
  logic [18:0] fail_vec;

  modport master (
    input  start, alu_y,
    output alu_a, alu_b, alu_op, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    output start, alu_y,
    input  alu_a, alu_b, alu_op, busy, done, pass, err_cnt, fail_vec
  );
endinterface

// File: rtl/alu_bist_ctrl.sv
// Sweeps all 2048 {op,b,a} vectors into a 4-bit ALU and checks alu_y against a golden model.
// Each vector takes SETTLE+1 cycles; no backpressure, start is ignored while a sweep is running.
module alu_bist_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  alu_bist_ctrl_if.master bus
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_DRIVE = 2'd1;
  localparam logic [1:0]  S_CHECK = 2'd2;
  localparam logic [1:0]  S_DONE  = 2'd3;
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [10:0] V_LAST = 11'h7FF;

  logic [1:0]  state;
  logic [10:0] v;
  logic [3:0]  settle_cnt;
  logic [7:0]  y_cap;
  logic [7:0]  err_cnt;
  logic [18:0] fail_vec;

  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [7:0]  r;
  logic [7:0]  exp_word;
  logic        mismatch;

  // Golden model: operands zero-extended to 8 bits, carry bit always expected 0.
  always_comb begin
    op_a = {4'h0, v[3:0]};
    op_b = {4'h0, v[7:4]};
    r    = 8'h00;
    case (v[10:8])
      3'd0: r = op_a + op_b;
      3'd1: r = op_a - op_b;
      3'd2: r = op_a * op_b;
      3'd3: r = (op_b != 8'h00) ? (op_a / op_b) : 8'h00;
      3'd4: r = op_a & op_b;
      3'd5: r = op_a | op_b;
      3'd6: r = ~op_a;
      3'd7: r = op_a ^ op_b;
    endcase
    exp_word = {(r == 8'h00), 1'b0, r[5:0]};
  end

  assign mismatch = (y_cap != exp_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      v          <= 11'd0;
      settle_cnt <= 4'd0;
      y_cap      <= 8'h00;
      err_cnt    <= 8'h00;
      fail_vec   <= 19'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state      <= S_DRIVE;
            v          <= 11'd0;
            settle_cnt <= 4'd0;
            err_cnt    <= 8'h00;
            fail_vec   <= 19'd0;
          end
        end
        S_DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            y_cap <= bus.alu_y;
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          // err_cnt still zero means this is the first mismatch of the sweep.
          if (mismatch) begin
            if (err_cnt == 8'h00) begin
              fail_vec <= {v, y_cap};
            end
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
          if (v == V_LAST) begin
            state <= S_DONE;
          end else begin
            v          <= v + 11'd1;
            settle_cnt <= 4'd0;
            state      <= S_DRIVE;
          end
        end
      endcase
    end
  end

  assign bus.alu_op   = v[10:8];
  assign bus.alu_b    = v[7:4];
  assign bus.alu_a    = v[3:0];
  assign bus.busy     = (state == S_DRIVE) || (state == S_CHECK);
  assign bus.done     = (state == S_DONE);
  assign bus.pass     = (state == S_DONE) && (err_cnt == 8'h00);
  assign bus.err_cnt  = err_cnt;
  assign bus.fail_vec = fail_vec;

endmodule
